// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    // Sequencer states:
    //   IDLE  | waiting for run
    //   REQ   | memory read outstanding for pc_q
    //   UPD   | commanding PC register to increment
    //   HOLD  | ir holds an instruction awaiting ir_ack
    //   BR    | commanding PC register to load the branch target
    //   FAULT | memory read timed out; sticky until clr
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        UPD   = 3'd2,
        HOLD  = 3'd3,
        BR    = 3'd4,
        FAULT = 3'd5
    } fetch_state_e;

    // Timeout counter width; a disabled timeout still needs a 1-bit vector.
    function automatic int ctr_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter for the memory read; flags the last permitted cycle.
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic cnt_en_i,
    output logic expire_o
);

    localparam int            CW    = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Count while enabled, clear otherwise, hold at LIMIT (LIMIT=0 keeps it at zero).
    always_comb begin
        count_d = count_q;
        if (!cnt_en_i) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire during the TIMEOUT-th enabled cycle so the next edge can leave REQ.
    assign expire_o = (TIMEOUT != 0) && cnt_en_i && (count_q == LAST);

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: reads instruction memory at pc_q, latches ir and steers
// the external PC register (increment after a fetch, load on a branch).
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_d,
    output logic              pc_en,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fault,
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              pend_q, pend_d;
    logic              expire;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .clr      (clr),
        .cnt_en_i (state_q == REQ),
        .expire_o (expire)
    );

    // Next-state logic: branch handling, read completion and timeout.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (branch_req) begin
                    tgt_d   = branch_target;
                    state_d = BR;
                end else if (run) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // The read is never aborted; a branch only marks its data as stale.
                if (branch_req) begin
                    tgt_d  = branch_target;
                    pend_d = 1'b1;
                end
                if (mem_ready) begin
                    pend_d = 1'b0;
                    if (pend_q || branch_req) begin
                        state_d = BR;
                    end else begin
                        ir_d    = mem_rdata;
                        state_d = UPD;
                    end
                end else if (expire) begin
                    pend_d  = 1'b0;
                    state_d = FAULT;
                end
            end
            UPD: begin
                if (branch_req) begin
                    tgt_d   = branch_target;
                    state_d = BR;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A branch in the ack cycle wins; the ack is simply absorbed.
                if (branch_req) begin
                    tgt_d   = branch_target;
                    state_d = BR;
                end else if (ir_ack) begin
                    state_d = run ? REQ : IDLE;
                end
            end
            BR: begin
                if (branch_req) begin
                    tgt_d   = branch_target;
                    state_d = BR;
                end else begin
                    state_d = run ? REQ : IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ir_q    <= '0;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        pc_d     = '0;
        pc_en    = 1'b0;
        pc_inc   = 1'b0;
        mem_addr = '0;
        mem_rd   = 1'b0;
        ir_valid = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            REQ: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
            end
            UPD: begin
                pc_en  = 1'b1;
                pc_inc = 1'b1;
                pc_d   = pc_q;
            end
            HOLD: begin
                ir_valid = 1'b1;
            end
            BR: begin
                pc_en = 1'b1;
                pc_d  = tgt_q;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ir   = ir_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_UPD   = 2;
    localparam int P_HOLD  = 3;
    localparam int P_BR    = 4;
    localparam int P_FAULT = 5;

    logic          clk = 1'b0;
    logic          clr, run, mem_ready, ir_ack, branch_req;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] pc_reg;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] pc_d, mem_addr;
    logic          pc_en, pc_inc, mem_rd, ir_valid, fault, busy;
    logic [DW-1:0] ir;
    logic          pc_set;
    logic [AW-1:0] pc_set_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_seq #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .run           (run),
        .pc_q          (pc_reg),
        .pc_d          (pc_d),
        .pc_en         (pc_en),
        .pc_inc        (pc_inc),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ir_ack        (ir_ack),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .fault         (fault),
        .busy          (busy)
    );

    // Instruction memory contents: word at 0x10 is DEADBEEF, rising by one per word.
    assign mem_rdata = 32'hDEADBEEF + (mem_addr - 32'h10);

    // External PC register driven by the sequencer.
    always @(posedge clk) begin
        if (pc_set) pc_reg <= pc_set_val;
        else if (pc_en) pc_reg <= pc_inc ? pc_d + 32'd1 : pc_d;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the fetch, instruction held, redirect target,
    // stale-read flag and cycles spent waiting on memory.
    int          m_ph   = P_IDLE;
    int          m_wait = 0;
    logic [31:0] m_ir   = '0;
    logic [31:0] m_tgt  = '0;
    bit          m_pend = 1'b0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin : ref_model
        int          ph, wt;
        logic [31:0] nir, ntgt;
        bit          pend;
        ph = m_ph; wt = m_wait; nir = m_ir; ntgt = m_tgt; pend = m_pend;
        if (clr) begin
            ph = P_IDLE; wt = 0; nir = '0; ntgt = '0; pend = 1'b0;
        end else begin
            case (ph)
                P_IDLE: begin
                    if (branch_req) begin ntgt = branch_target; ph = P_BR; end
                    else if (run) ph = P_REQ;
                end
                P_REQ: begin
                    if (branch_req) begin ntgt = branch_target; pend = 1'b1; end
                    if (mem_ready) begin
                        if (pend) ph = P_BR;
                        else begin nir = mem_rdata; ph = P_UPD; end
                        pend = 1'b0;
                    end else begin
                        wt = wt + 1;
                        if (TO != 0 && wt >= TO) ph = P_FAULT;
                    end
                end
                P_UPD, P_HOLD, P_BR: begin
                    if (branch_req) begin ntgt = branch_target; ph = P_BR; end
                    else if (ph == P_UPD) ph = P_HOLD;
                    else if (ph == P_BR) ph = run ? P_REQ : P_IDLE;
                    else if (ir_ack) ph = run ? P_REQ : P_IDLE;
                end
                default: ph = P_FAULT;
            endcase
        end
        if (ph != P_REQ) wt = 0;
        m_ph <= ph; m_wait <= wt; m_ir <= nir; m_tgt <= ntgt; m_pend <= pend;
        if (clr) m_live <= 1'b1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_mem_rd", mem_rd, m_ph == P_REQ);
            chk("m_mem_addr", mem_addr, (m_ph == P_REQ) ? pc_reg : 32'h0);
            chk("m_pc_en", pc_en, (m_ph == P_UPD) || (m_ph == P_BR));
            chk("m_pc_inc", pc_inc, m_ph == P_UPD);
            chk("m_pc_d", pc_d, (m_ph == P_UPD) ? pc_reg : (m_ph == P_BR) ? m_tgt : 32'h0);
            chk("m_ir", ir, m_ir);
            chk("m_ir_valid", ir_valid, m_ph == P_HOLD);
            chk("m_fault", fault, m_ph == P_FAULT);
            chk("m_busy", busy, m_ph != P_IDLE);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] fa[$];
    int            fc[$];

    initial begin
        clr = 1; run = 1; mem_ready = 0; ir_ack = 0; branch_req = 0;
        branch_target = '0; pc_set = 1; pc_set_val = 32'h10;

        // Reset held two cycles with run high
        step(); step();
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_pc_inc", pc_inc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        clr = 0; pc_set = 0;

        // First fetch with two wait cycles
        step(); #1; chk("t1_req1_rd", mem_rd, 1); chk("t1_req1_addr", mem_addr, 32'h10);
        step(); #1; chk("t1_req2_addr", mem_addr, 32'h10);
        step(); mem_ready = 1; #1; chk("t1_req3_rd", mem_rd, 1); chk("t1_req3_addr", mem_addr, 32'h10);
        step(); mem_ready = 0; #1;
        chk("t1_upd_en", pc_en, 1); chk("t1_upd_inc", pc_inc, 1); chk("t1_upd_d", pc_d, 32'h10);
        step(); #1;
        chk("t1_hold_ir", ir, 32'hDEADBEEF); chk("t1_hold_v", ir_valid, 1); chk("t1_pc", pc_reg, 32'h11);

        // Stall in HOLD without ack
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("t3_ir", ir, 32'hDEADBEEF); chk("t3_v", ir_valid, 1); chk("t3_rd", mem_rd, 0);
        end
        step(); ir_ack = 1; #1; chk("t3_ack_v", ir_valid, 1);
        step(); ir_ack = 0; branch_req = 1; branch_target = 32'h300; #1;
        chk("t3_req_rd", mem_rd, 1); chk("t3_req_addr", mem_addr, 32'h11);

        // Branch during a read wait, second branch overwrites the target
        step(); branch_target = 32'h200; #1; chk("t4_req2_rd", mem_rd, 1);
        step(); branch_req = 0; mem_ready = 1; #1; chk("t4_req3_rd", mem_rd, 1);
        step(); mem_ready = 0; #1;
        chk("t4_br_en", pc_en, 1); chk("t4_br_inc", pc_inc, 0); chk("t4_br_d", pc_d, 32'h200);
        chk("t4_br_ir", ir, 32'hDEADBEEF); chk("t4_br_v", ir_valid, 0);
        step(); mem_ready = 1; #1; chk("t4_req_addr", mem_addr, 32'h200);
        step(); mem_ready = 0; #1; chk("t4_upd_d", pc_d, 32'h200);
        step(); #1; chk("t4_hold_ir", ir, 32'hDEADC0DF); chk("t4_pc", pc_reg, 32'h201);

        // Branch together with ack in HOLD
        branch_req = 1; branch_target = 32'h400; ir_ack = 1;
        step(); branch_req = 0; ir_ack = 0; #1;
        chk("t4b_br_d", pc_d, 32'h400); chk("t4b_br_inc", pc_inc, 0);
        chk("t4b_br_v", ir_valid, 0); chk("t4b_br_ir", ir, 32'hDEADC0DF);
        step(); #1; chk("t4b_req_addr", mem_addr, 32'h400);

        // clr mid-REQ, then mid-UPD
        clr = 1;
        step(); clr = 0; mem_ready = 1; #1;
        chk("t6a_rd", mem_rd, 0); chk("t6a_en", pc_en, 0); chk("t6a_ir", ir, 0); chk("t6a_busy", busy, 0);
        step(); #1; chk("t6b_req_addr", mem_addr, 32'h400);
        step(); mem_ready = 0; clr = 1; #1; chk("t6b_upd_en", pc_en, 1);
        step(); clr = 0; run = 0; #1;
        chk("t6b_en", pc_en, 0); chk("t6b_inc", pc_inc, 0); chk("t6b_ir", ir, 0);
        chk("t6b_busy", busy, 0); chk("t6b_pc", pc_reg, 32'h401);
        step(); #1; chk("t6b_idle_en", pc_en, 0);

        // Memory never ready: fault after the 4th REQ cycle
        run = 1;
        for (int i = 0; i < 4; i++) begin
            step(); #1; chk("t5_req_rd", mem_rd, 1); chk("t5_req_fault", fault, 0);
        end
        step(); branch_req = 1; branch_target = 32'h500; #1;
        chk("t5_fault", fault, 1); chk("t5_rd", mem_rd, 0); chk("t5_busy", busy, 1);
        step(); branch_req = 0; #1;
        chk("t5_fault_hold", fault, 1); chk("t5_en", pc_en, 0); chk("t5_d", pc_d, 0);
        clr = 1;
        step(); clr = 0; run = 0; #1;
        chk("t5_clr_fault", fault, 0); chk("t5_clr_busy", busy, 0);

        // Zero-wait streaming with ack tied high
        clr = 1; pc_set = 1; pc_set_val = 32'h10; run = 1; ir_ack = 1; mem_ready = 1;
        step(); clr = 0; pc_set = 0;
        for (int k = 0; k < 12; k++) begin
            step(); #1;
            if (mem_rd && mem_ready) begin
                fa.push_back(mem_addr);
                fc.push_back(k);
            end
        end
        chk("t2_nfetch", fa.size(), 4);
        for (int i = 0; i < fa.size() && i < 3; i++) chk("t2_addr", fa[i], 32'h10 + i);
        for (int i = 1; i < fc.size() && i < 4; i++) chk("t2_cadence", fc[i] - fc[i-1], 3);

        run = 0; ir_ack = 0; mem_ready = 0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
